// File: rtl/tile_pkg.sv
// Shared types and constants for the tile-to-pixel fetch pipeline.
package tile_pkg;

    localparam int TILE_PX     = 8;
    localparam int BPP         = 2;
    localparam int TILES_W_DEF = 28;
    localparam int TILES_H_DEF = 36;

    typedef logic [7:0]  tile_code_t;
    typedef logic [9:0]  tile_addr_t;
    typedef logic [15:0] pat_row_t;

    typedef struct packed {
        logic       win;
        logic [2:0] px;
        logic [2:0] py;
        logic       hs;
        logic       vs;
    } pix_meta_t;

    localparam int META_W = $bits(pix_meta_t);

    // Pixel 0 lives in the top two bits; {~px,1} is 15-2*px.
    function automatic logic [BPP-1:0] pick_pixel(input pat_row_t pat, input logic [2:0] px);
        return pat[{~px, 1'b1} -: BPP];
    endfunction

endpackage

// File: rtl/tile_pixel_fetch_pipe_delay.sv
// Fixed-depth async-reset shift register used to carry pixel metadata.
module pipe_delay
    import tile_pkg::*;
#(
    parameter int WIDTH = META_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tile_pixel_fetch.sv
// Scan position -> tile RAM -> pattern ROM -> colour index, fixed 5-clock latency.
// Optional per-tile palette lookup is enabled by defining TILE_PALETTE_EN.
module tile_pixel_fetch
    import tile_pkg::*;
#(
    parameter int H_START = 208,
    parameter int V_START = 96,
    parameter int TILES_W = TILES_W_DEF,
    parameter int TILES_H = TILES_H_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  col,
    input  logic [9:0]  row,
    input  logic        active,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [9:0]  tram_addr,
    input  logic [7:0]  tram_data,
    output logic [10:0] pram_addr,
    input  logic [15:0] pram_data,
`ifdef TILE_PALETTE_EN
    output logic [9:0]  cram_addr,
    input  logic [3:0]  cram_data,
`endif
    output logic [5:0]  pix_color,
    output logic        pix_en,
    output logic        hs_out,
    output logic        vs_out
);

    localparam logic [9:0] H_ORG  = 10'(H_START);
    localparam logic [9:0] V_ORG  = 10'(V_START);
    localparam logic [9:0] H_SPAN = 10'(TILE_PX * TILES_W);
    localparam logic [9:0] V_SPAN = 10'(TILE_PX * TILES_H);

    logic [9:0]  dx, dy, tx, ty, row_base;
    logic        in_win;
    tile_addr_t  addr_d, tram_addr_q;
    pix_meta_t   meta_d, meta_s1_q, meta_s2_q, meta_s4;
    logic [10:0] pram_addr_q;
    logic [5:0]  pix_color_q;
    logic        pix_en_q, hs_q, vs_q;
    logic [3:0]  pal_sel;
    logic [2:0]  py_s4_unused;

    assign dx = col - H_ORG;
    assign dy = row - V_ORG;
    // Explicit >= start keeps wrapped subtractions from looking in-window.
    assign in_win = active && (col >= H_ORG) && (dx < H_SPAN)
                           && (row >= V_ORG) && (dy < V_SPAN);
    assign tx = {3'b000, dx[9:3]};
    assign ty = {3'b000, dy[9:3]};
    assign row_base = (ty << 4) + (ty << 3) + (ty << 2);

    always_comb begin
        meta_d    = '0;
        addr_d    = '0;
        meta_d.hs = hs_in;
        meta_d.vs = vs_in;
        if (in_win) begin
            meta_d.win = 1'b1;
            meta_d.px  = dx[2:0];
            meta_d.py  = dy[2:0];
            addr_d     = row_base + tx;
        end
    end

    // S1 issues the tile RAM address, S2 waits out its read, S3 issues the ROM address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tram_addr_q <= '0;
            meta_s1_q   <= '0;
            meta_s2_q   <= '0;
            pram_addr_q <= '0;
        end else begin
            tram_addr_q <= addr_d;
            meta_s1_q   <= meta_d;
            meta_s2_q   <= meta_s1_q;
            pram_addr_q <= {tram_data, meta_s2_q.py};
        end
    end

    pipe_delay #(.WIDTH(META_W), .DEPTH(2)) u_meta_dly (
        .clk   (clk),
        .reset (reset),
        .d_i   (meta_s2_q),
        .q_o   (meta_s4)
    );

    assign py_s4_unused = meta_s4.py;

`ifdef TILE_PALETTE_EN
    tile_addr_t addr_s2_q, cram_addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_s2_q   <= '0;
            cram_addr_q <= '0;
        end else begin
            addr_s2_q   <= tram_addr_q;
            cram_addr_q <= addr_s2_q;
        end
    end

    assign cram_addr = cram_addr_q;
    assign pal_sel   = cram_data;
`else
    assign pal_sel = 4'h0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_color_q <= '0;
            pix_en_q    <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            pix_color_q <= meta_s4.win ? {pal_sel, pick_pixel(pram_data, meta_s4.px)} : 6'd0;
            pix_en_q    <= meta_s4.win;
            hs_q        <= meta_s4.hs;
            vs_q        <= meta_s4.vs;
        end
    end

    assign tram_addr = tram_addr_q;
    assign pram_addr = pram_addr_q;
    assign pix_color = pix_color_q;
    assign pix_en    = pix_en_q;
    assign hs_out    = hs_q;
    assign vs_out    = vs_q;

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Scoreboard bench for tile_pixel_fetch with behavioural tile RAM, pattern ROM and palette RAM.
module tb_tile_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  col, row;
    logic        active, hs_in, vs_in;
    logic [9:0]  tram_addr;
    logic [7:0]  tram_data;
    logic [10:0] pram_addr;
    logic [15:0] pram_data;
`ifdef TILE_PALETTE_EN
    logic [9:0]  cram_addr;
    logic [3:0]  cram_data;
`endif
    logic [5:0]  pix_color;
    logic        pix_en, hs_out, vs_out;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit pat_mode = 1'b0;

    typedef struct {
        int          due;
        logic [9:0]  tram;
        logic        chk_pram;
        logic [10:0] pram;
        logic [5:0]  color;
        logic        en;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t q_tram[$];
    exp_t q_pram[$];
    exp_t q_pix[$];

    tile_pixel_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .active    (active),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .tram_addr (tram_addr),
        .tram_data (tram_data),
        .pram_addr (pram_addr),
        .pram_data (pram_data),
`ifdef TILE_PALETTE_EN
        .cram_addr (cram_addr),
        .cram_data (cram_data),
`endif
        .pix_color (pix_color),
        .pix_en    (pix_en),
        .hs_out    (hs_out),
        .vs_out    (vs_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] code_of(input logic [9:0] a);
        return a[7:0] ^ {6'd0, a[9:8]} ^ 8'hA5;
    endfunction

    function automatic logic [15:0] pat_of(input logic [10:0] a, input bit m);
        return m ? ({a[10:3], ~a[7:0]} ^ 16'h3C5A) : 16'hE41B;
    endfunction

    function automatic logic [3:0] pal_of(input logic [9:0] a);
        return a[3:0] ^ 4'hA;
    endfunction

    // Synchronous memories: sample address on the edge, data valid the following cycle.
    always @(posedge clk) begin
        tram_data <= code_of(tram_addr);
        pram_data <= pat_of(pram_addr, pat_mode);
`ifdef TILE_PALETTE_EN
        cram_data <= pal_of(cram_addr);
`endif
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one scan position and records what must come out of each stage.
    task automatic drive(input int c, input int r, input bit act, input bit h, input bit v);
        exp_t        e;
        bit          w;
        int          px, py;
        logic [9:0]  addr;
        logic [7:0]  code;
        logic [15:0] pat, sh;
        logic [3:0]  pal;
        col    = 10'(c);
        row    = 10'(r);
        active = act;
        hs_in  = h;
        vs_in  = v;
        w    = act && (c >= 208) && (c < 432) && (r >= 96) && (r < 384);
        px   = w ? (c - 208) % 8 : 0;
        py   = w ? (r - 96) % 8 : 0;
        addr = w ? 10'(((r - 96) / 8) * 28 + (c - 208) / 8) : 10'd0;
        code = code_of(addr);
        pat  = pat_of({code, 3'(py)}, pat_mode);
        sh   = pat >> (14 - 2 * px);
`ifdef TILE_PALETTE_EN
        pal = pal_of(addr);
`else
        pal = 4'h0;
`endif
        e.tram     = addr;
        e.chk_pram = w;
        e.pram     = {code, 3'(py)};
        e.color    = w ? {pal, sh[1:0]} : 6'd0;
        e.en       = w;
        e.hs       = h;
        e.vs       = v;
        if (reset) begin
            e.tram = '0; e.chk_pram = 1'b0; e.color = '0; e.en = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
        end
        e.due = cyc + 1; q_tram.push_back(e);
        e.due = cyc + 3; q_pram.push_back(e);
        e.due = cyc + 5; q_pix.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q_tram.size() > 0 && q_tram[0].due <= cyc) begin
            e = q_tram.pop_front();
            if (e.due != cyc) chk("tram_late", 16'(e.due), 16'(cyc));
            else chk("tram_addr", 16'(tram_addr), 16'(e.tram));
        end
        while (q_pram.size() > 0 && q_pram[0].due <= cyc) begin
            e = q_pram.pop_front();
            if (e.due != cyc) chk("pram_late", 16'(e.due), 16'(cyc));
            else if (e.chk_pram) chk("pram_addr", 16'(pram_addr), 16'(e.pram));
        end
        while (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
            e = q_pix.pop_front();
            if (e.due != cyc) chk("pix_late", 16'(e.due), 16'(cyc));
            else chk("pix_out", {8'd0, hs_out, vs_out, pix_en, pix_color[4:0] & 5'h1F} | {10'd0, pix_color[5], 5'd0},
                     {8'd0, e.hs, e.vs, e.en, e.color[4:0]} | {10'd0, e.color[5], 5'd0});
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_tram"},  16'(tram_addr), 16'd0);
        chk({tag, "_pram"},  16'(pram_addr), 16'd0);
        chk({tag, "_color"}, 16'(pix_color), 16'd0);
        chk({tag, "_en"},    16'(pix_en),    16'd0);
        chk({tag, "_hs"},    16'(hs_out),    16'd0);
        chk({tag, "_vs"},    16'(vs_out),    16'd0);
    endtask

    initial begin
        int budget;
        reset = 1'b1; col = '0; row = '0; active = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // First row sweep across the left edge with a fixed pattern row.
        pat_mode = 1'b0;
        for (int c = 204; c <= 223; c++)
            drive(c, 96, 1'b1, (c >= 210) && (c < 213), (c == 215) || (c == 216));
        idle(6);

        // Address arithmetic, far corner and out-of-window cases.
        pat_mode = 1'b1;
        drive(216, 104, 1'b1, 1'b0, 1'b0);
        drive(217, 104, 1'b1, 1'b0, 1'b0);
        drive(430, 383, 1'b1, 1'b0, 1'b0);
        drive(431, 383, 1'b1, 1'b1, 1'b0);
        drive(432, 383, 1'b1, 1'b0, 1'b0);
        drive(300, 384, 1'b1, 1'b0, 1'b1);
        drive(300, 200, 1'b0, 1'b0, 1'b0);
        drive(207, 200, 1'b1, 1'b0, 1'b0);
        drive(300, 95,  1'b1, 1'b0, 1'b0);
        drive(215, 300, 1'b1, 1'b1, 1'b1);
        drive(0, 96,    1'b1, 1'b0, 1'b0);
        drive(223, 379, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a line.
        for (int c = 220; c <= 227; c++) drive(c, 120, 1'b1, c >= 225, 1'b0);
        reset = 1'b1;
        foreach (q_tram[i]) q_tram[i].tram = '0;
        foreach (q_pram[i]) begin q_pram[i].chk_pram = 1'b1; q_pram[i].pram = '0; end
        foreach (q_pix[i]) begin
            q_pix[i].color = '0; q_pix[i].en = 1'b0; q_pix[i].hs = 1'b0; q_pix[i].vs = 1'b0;
        end
        #1;
        check_zero("midrst");
        for (int c = 228; c <= 230; c++) drive(c, 120, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        for (int c = 231; c <= 245; c++) drive(c, 120, 1'b1, c < 233, c == 240);
        idle(6);

        budget = 0;
        while ((q_tram.size() + q_pram.size() + q_pix.size()) > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #1;
        chk("drain", 16'(q_tram.size() + q_pram.size() + q_pix.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tile_pixel_fetch.md
# tile_pixel_fetch

Streaming tile-to-pixel stage between the VGA timing generator and the colour/palette output. For each scan position it translates (col,row) into a tile-RAM address, fetches the 8-bit tile code, then the 16-bit 2bpp pattern row, and emits one colour index per clock. Sync signals are delayed to stay aligned with pixels. The screen is a fixed 28x36 grid of 8x8 tiles (224x288 px) placed at a parameterised offset.

## Interface
- H_START, 208, first active column of the tile window
- V_START, 96, first active row of the tile window
- TILES_W, 28, tiles per row
- TILES_H, 36, tile rows

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- col  in  10  current column from timing generator
- row  in  10  current row
- active  in  1  timing generator is in visible area
- hs_in, vs_in  in  1  syncs, same cycle as col/row
- tram_addr  out  10  tile RAM address, row-major y*TILES_W+x
- tram_data  in  8  tile code, valid the cycle after the RAM samples tram_addr
- pram_addr  out  11  pattern ROM address {code, tile_row[2:0]}
- pram_data  in  16  pattern row, same 1-cycle read latency; pixel 0 = bits [15:14]
- cram_addr  out  10  palette RAM address (TILE_PALETTE_EN only)
- cram_data  in  4  palette select per tile (TILE_PALETTE_EN only)
- pix_color  out  6  {palette[3:0], pixel[1:0]}
- pix_en  out  1  pix_color is inside the tile window
- hs_out, vs_out  out  1  delayed syncs

## Operation
- In-window: active && H_START<=col<H_START+8*TILES_W && V_START<=row<V_START+8*TILES_H. Compute with 10-bit subtraction, no wrap: values below the start are out-of-window.
- tx=(col-H_START)>>3, ty=(row-V_START)>>3, px=(col-H_START)[2:0], py=(row-V_START)[2:0].
- Compute ty*28 as (ty<<4)+(ty<<3)+(ty<<2), 10-bit. The maximum address is 1007.
- Out-of-window: tram_addr=0 and the entry's window flag is 0. The downstream result is pix_en=0 and pix_color=0, regardless of RAM data.
- Pipeline stages, each a register:
  - S1 registers tram_addr, px, py, window flag and syncs.
  - S2 holds metadata while tile RAM reads.
  - S3 registers pram_addr={tram_data,py} and, with TILE_PALETTE_EN, cram_addr=S1 address.
  - S4 holds metadata while the ROM reads.
  - S5 registers pix_color=pram_data[15-2*px -: 2] and pix_en.
- No stalls and no backpressure; one pixel per clock, always.

## Timing
- Latency is exactly 5 clocks from col/row/hs_in/vs_in to pix_color/pix_en/hs_out/vs_out.
- RAM/ROM contract: the address is registered by this block, sampled by the memory on the next edge, and data is valid during the following cycle.
- Tile boundary (px 7->0): the new tram_addr is issued with no bubble. Consecutive tiles produce back-to-back pixels.
- Line/frame wrap: col/row discontinuities pass straight through; there is no internal scan state.
- Reset (asserted at any time, including mid-line): all outputs and pipeline registers are 0 immediately. hs_out/vs_out=0. The first valid output is 5 clocks after deassert.

## Configuration
- TILE_PALETTE_EN defined:
  - cram_addr/cram_data ports exist.
  - The palette is read in parallel with the pattern ROM and aligned to S5.
  - pix_color[5:2]=palette.
- Undefined: the cram ports and registers are removed, and pix_color[5:2]=0.

## Structure
- Package tile_pkg holds:
  - TILE_PX=8, BPP=2, default TILES_W/TILES_H.
  - typedefs tile_code_t (8b), tile_addr_t (10b), pat_row_t (16b), pix_meta_t struct {win, px, py, hs, vs}.
- One sub-module: pipe_delay #(WIDTH, DEPTH), an async-reset shift register carrying pix_meta_t through the stages.

## Test plan
- Reset, then sweep the first row: col=208,row=96 -> tram_addr=0. Five clocks later pix_en=1 and pix_color=pram_data[15:14].
- Tile with pram_data=16'hE41B, px 0..7 -> pix_color 3,2,1,0,0,1,2,3 in consecutive clocks.
- col=216,row=104 -> tram_addr=29. col=431,row=383 -> tram_addr=1007, pram_addr={code,3'd7}.
- col=207 / col=432 / row=384 / active=0 -> pix_en=0 and pix_color=0 with RAMs returning nonzero data.
- hs_in pulse at cycle N -> hs_out pulse at cycle N+5, same width. Reset mid-line forces all outputs to 0 the same cycle, and output resumes 5 clocks after release.
- With TILE_PALETTE_EN, cram_data=4'hA for the tile -> pix_color[5:2]=4'hA aligned with its pixels. Without the macro -> pix_color[5:2]=0.
